// File: rtl/onehot_pkg.sv
// Shared definitions for one-hot sequence consumers.
//   state_t   : checker FSM states
//   CNT_W_DEF : default counter width
//   rotl1     : expected successor of an n-bit one-hot code (rotate-left by 1)
package onehot_pkg;

  typedef enum logic {
    S_SYNC = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  localparam int CNT_W_DEF = 8;

  // Operates on a 32-bit container so it can serve any width up to 32;
  // callers narrow the result back to their own width.
  function automatic logic [31:0] rotl1(input logic [31:0] code, input int n);
    logic [31:0] mask;
    mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    return ((code << 1) | (code >> (n - 1))) & mask;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to binary encoder.
//   code  : N-bit one-hot code
//   legal : exactly one bit of code is set
//   idx   : index of the set bit (meaningful only when legal)
module onehot_enc #(
  parameter int N     = 3,
  parameter int ENC_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     code,
  output logic             legal,
  output logic [ENC_W-1:0] idx
);

  localparam logic [N-1:0] ONE = N'(1);

  always_comb begin
    // Clearing the lowest set bit leaves zero only for a single-bit code.
    legal = (code != '0) && ((code & (code - ONE)) == '0);
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (code[i]) idx = idx | ENC_W'(i);
    end
  end

endmodule

// File: rtl/onehot_seq_checker.sv
// Checker for a one-hot ring FSM output (001 -> 010 -> 100 -> 001 ...).
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : sample enable, 0 freezes FSM and counters
//   clr          : synchronous clear of counters and err_sticky
//   onehot_in    : code from the upstream ring FSM
//   state_bin    : binary index of the last legal sample
//   locked       : tracking a legal sequence
//   illegal_p    : pulse, last sample not one-hot
//   seq_err_p    : pulse, legal sample but wrong successor
//   err_sticky   : any error since reset/clr
//   illegal_cnt  : saturating count of illegal samples
//   seq_err_cnt  : saturating count of sequence errors
//   rot_cnt      : wrapping count of completed rotations
//
// state  | meaning
// S_SYNC | waiting for a legal code to lock onto, no sequence check
// S_LOCK | tracking; each sample must be the rotate-left successor of prev
module onehot_seq_checker
  import onehot_pkg::*;
#(
  parameter int  N          = 3,
  parameter int  CNT_W      = CNT_W_DEF,
  parameter bit  ALLOW_HOLD = 1'b0,
  localparam int ENC_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [N-1:0]     onehot_in,
  output logic [ENC_W-1:0] state_bin,
  output logic             locked,
  output logic             illegal_p,
  output logic             seq_err_p,
  output logic             err_sticky,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [CNT_W-1:0] seq_err_cnt,
  output logic [CNT_W-1:0] rot_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [N-1:0]     prev, prev_nxt, succ;
  logic [ENC_W-1:0] bin_nxt, idx;
  logic             legal, ill_ev, seq_ev, rot_ev;

  onehot_enc #(.N(N), .ENC_W(ENC_W)) u_enc (
    .code  (onehot_in),
    .legal (legal),
    .idx   (idx)
  );

  assign succ   = N'(rotl1(32'(prev), N));
  assign locked = (state == S_LOCK);

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    bin_nxt   = state_bin;
    ill_ev    = 1'b0;
    seq_ev    = 1'b0;
    rot_ev    = 1'b0;
    if (en) begin
      case (state)
        S_SYNC: begin
          if (legal) begin
            state_nxt = S_LOCK;
            prev_nxt  = onehot_in;
            bin_nxt   = idx;
          end else begin
            ill_ev = 1'b1;
          end
        end
        S_LOCK: begin
          if (!legal) begin
            // state_bin keeps the last legal index while resyncing
            ill_ev    = 1'b1;
            state_nxt = S_SYNC;
          end else if (onehot_in == succ) begin
            prev_nxt = onehot_in;
            bin_nxt  = idx;
            rot_ev   = prev[N-1] & onehot_in[0];
          end else if (!(ALLOW_HOLD && (onehot_in == prev))) begin
            // wrong successor: flag it and resync onto the new code
            seq_ev   = 1'b1;
            prev_nxt = onehot_in;
            bin_nxt  = idx;
          end
        end
        default: state_nxt = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_SYNC;
      prev        <= '0;
      state_bin   <= '0;
      illegal_p   <= 1'b0;
      seq_err_p   <= 1'b0;
      err_sticky  <= 1'b0;
      illegal_cnt <= '0;
      seq_err_cnt <= '0;
      rot_cnt     <= '0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      state_bin <= bin_nxt;
      illegal_p <= ill_ev;
      seq_err_p <= seq_ev;
      if (clr) begin
        // clear wins over this cycle's events; pulses above still fire
        err_sticky  <= 1'b0;
        illegal_cnt <= '0;
        seq_err_cnt <= '0;
        rot_cnt     <= '0;
      end else begin
        if (ill_ev || seq_ev) err_sticky <= 1'b1;
        if (ill_ev && (illegal_cnt != CNT_MAX)) illegal_cnt <= illegal_cnt + CNT_ONE;
        if (seq_ev && (seq_err_cnt != CNT_MAX)) seq_err_cnt <= seq_err_cnt + CNT_ONE;
        if (rot_ev) rot_cnt <= rot_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_onehot_seq_checker.sv
// Scoreboard bench: three checker instances (default, hold-allowed, 2-bit
// counters) share one stimulus stream; an index-level reference model pushes
// the expected outputs, and a monitor pops and compares after each edge.
module tb_onehot_seq_checker;

  typedef struct packed {
    logic [1:0] bin;
    logic       locked;
    logic       ill;
    logic       seq;
    logic       sticky;
    logic [7:0] icnt;
    logic [7:0] scnt;
    logic [7:0] rcnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] onehot_in = 3'b000;

  always #5 clk = ~clk;

  logic [1:0] d_bin, h_bin, c_bin;
  logic       d_lock, h_lock, c_lock, d_ill, h_ill, c_ill;
  logic       d_seq, h_seq, c_seq, d_st, h_st, c_st;
  logic [7:0] d_ic, d_sc, d_rc, h_ic, h_sc, h_rc;
  logic [1:0] c_ic, c_sc, c_rc;

  onehot_seq_checker #(.N(3), .CNT_W(8), .ALLOW_HOLD(1'b0)) u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .onehot_in(onehot_in),
    .state_bin(d_bin), .locked(d_lock), .illegal_p(d_ill), .seq_err_p(d_seq),
    .err_sticky(d_st), .illegal_cnt(d_ic), .seq_err_cnt(d_sc), .rot_cnt(d_rc));

  onehot_seq_checker #(.N(3), .CNT_W(8), .ALLOW_HOLD(1'b1)) u_hold (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .onehot_in(onehot_in),
    .state_bin(h_bin), .locked(h_lock), .illegal_p(h_ill), .seq_err_p(h_seq),
    .err_sticky(h_st), .illegal_cnt(h_ic), .seq_err_cnt(h_sc), .rot_cnt(h_rc));

  onehot_seq_checker #(.N(3), .CNT_W(2), .ALLOW_HOLD(1'b0)) u_c2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .onehot_in(onehot_in),
    .state_bin(c_bin), .locked(c_lock), .illegal_p(c_ill), .seq_err_p(c_seq),
    .err_sticky(c_st), .illegal_cnt(c_ic), .seq_err_cnt(c_sc), .rot_cnt(c_rc));

  obs_t act [3];
  always_comb begin
    act[0] = '{bin: d_bin, locked: d_lock, ill: d_ill, seq: d_seq, sticky: d_st,
               icnt: d_ic, scnt: d_sc, rcnt: d_rc};
    act[1] = '{bin: h_bin, locked: h_lock, ill: h_ill, seq: h_seq, sticky: h_st,
               icnt: h_ic, scnt: h_sc, rcnt: h_rc};
    act[2] = '{bin: c_bin, locked: c_lock, ill: c_ill, seq: c_seq, sticky: c_st,
               icnt: {6'b0, c_ic}, scnt: {6'b0, c_sc}, rcnt: {6'b0, c_rc}};
  end

  int errors = 0;
  int checks = 0;
  obs_t q_exp[$];

  // reference model state, per instance, kept as plain indices and integers
  int m_hold [3] = '{0, 1, 0};
  int m_max  [3] = '{255, 255, 3};
  int m_locked [3];
  int m_last   [3];
  int m_icnt   [3];
  int m_scnt   [3];
  int m_rcnt   [3];
  int m_sticky [3];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic compare(input int k, input obs_t a, input obs_t e);
    string p;
    p = (k == 0) ? "def" : (k == 1) ? "hold" : "cnt2";
    check({p, ".state_bin"},   int'(a.bin),    int'(e.bin));
    check({p, ".locked"},      int'(a.locked), int'(e.locked));
    check({p, ".illegal_p"},   int'(a.ill),    int'(e.ill));
    check({p, ".seq_err_p"},   int'(a.seq),    int'(e.seq));
    check({p, ".err_sticky"},  int'(a.sticky), int'(e.sticky));
    check({p, ".illegal_cnt"}, int'(a.icnt),   int'(e.icnt));
    check({p, ".seq_err_cnt"}, int'(a.scnt),   int'(e.scnt));
    check({p, ".rot_cnt"},     int'(a.rcnt),   int'(e.rcnt));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_locked[k] = 0; m_last[k] = 0; m_icnt[k] = 0;
      m_scnt[k] = 0; m_rcnt[k] = 0; m_sticky[k] = 0;
    end
  endtask

  // Apply one sample at the falling edge and push what each instance
  // should show after the following rising edge.
  task automatic step(input logic e, input logic c, input logic [2:0] code);
    obs_t x;
    int   idx;
    bit   ill, seq, rot;
    @(negedge clk);
    en = e; clr = c; onehot_in = code;
    for (int k = 0; k < 3; k++) begin
      ill = 0; seq = 0; rot = 0;
      if (e) begin
        if ($countones(code) != 1) begin
          ill = 1;
          m_locked[k] = 0;
        end else begin
          idx = $clog2(code);
          if (m_locked[k] == 0) begin
            m_locked[k] = 1;
            m_last[k] = idx;
          end else if (idx == (m_last[k] + 1) % 3) begin
            if (idx == 0) rot = 1;
            m_last[k] = idx;
          end else if (idx == m_last[k] && m_hold[k] != 0) begin
          end else begin
            seq = 1;
            m_last[k] = idx;
          end
        end
      end
      if (c) begin
        m_icnt[k] = 0; m_scnt[k] = 0; m_rcnt[k] = 0; m_sticky[k] = 0;
      end else begin
        if (ill && m_icnt[k] < m_max[k]) m_icnt[k]++;
        if (seq && m_scnt[k] < m_max[k]) m_scnt[k]++;
        if (rot) m_rcnt[k] = (m_rcnt[k] + 1) % (m_max[k] + 1);
        if (ill || seq) m_sticky[k] = 1;
      end
      x.bin    = 2'(m_last[k]);
      x.locked = (m_locked[k] != 0);
      x.ill    = ill;
      x.seq    = seq;
      x.sticky = (m_sticky[k] != 0);
      x.icnt   = 8'(m_icnt[k]);
      x.scnt   = 8'(m_scnt[k]);
      x.rcnt   = 8'(m_rcnt[k]);
      q_exp.push_back(x);
    end
  endtask

  // monitor: outputs are registered, so compare 1 time unit after each edge
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q_exp.size() >= 3) begin
        for (int k = 0; k < 3; k++) begin
          e = q_exp.pop_front();
          compare(k, act[k], e);
        end
      end
    end
  end

  task automatic async_reset_check();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) compare(k, act[k], '0);
    model_reset();
    en = 1'b0; clr = 1'b0; onehot_in = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] code;
    logic [2:0] bad [5];
    int r, cur;
    bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101; bad[3] = 3'b110; bad[4] = 3'b111;
    model_reset();

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) compare(k, act[k], '0);
    rst_n = 1'b1;

    // clean rotations
    step(1, 0, 3'b001); step(1, 0, 3'b010); step(1, 0, 3'b100); step(1, 0, 3'b001);
    step(1, 0, 3'b010); step(1, 0, 3'b100); step(1, 0, 3'b001);
    // illegal while locked on 010, then relock on 100
    step(1, 0, 3'b010); step(1, 0, 3'b011); step(1, 0, 3'b100); step(1, 0, 3'b001);
    // skip from 001 to 100, then 001 completes a rotation
    step(1, 0, 3'b100); step(1, 0, 3'b001);
    // repeated code
    step(1, 0, 3'b010); step(1, 0, 3'b010); step(1, 0, 3'b100);
    // saturation, then clear coinciding with another illegal sample
    repeat (5) step(1, 0, 3'b000);
    step(1, 1, 3'b000);
    step(1, 0, 3'b001); step(1, 0, 3'b010);
    // asynchronous reset between edges
    async_reset_check();
    step(1, 0, 3'b001); step(1, 0, 3'b010);
    // disabled sampling with toggling input
    step(0, 0, 3'b100); step(0, 0, 3'b011); step(0, 0, 3'b001);
    step(0, 1, 3'b111);
    step(1, 0, 3'b100);

    // randomized mix
    cur = 2;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       begin cur = (cur + 1) % 3; code = 3'(1 << cur); end
      else if (r == 6) code = 3'(1 << cur);
      else if (r == 7) begin cur = $urandom_range(0, 2); code = 3'(1 << cur); end
      else if (r == 8) code = bad[$urandom_range(0, 4)];
      else             code = 3'($urandom_range(0, 7));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, code);
    end

    @(posedge clk);
    #5;
    check("scoreboard_drained", q_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
